// File: rtl/dmem_arbiter.sv
// dmem_arbiter: per-cycle arbiter sharing one data-memory port between the CPU and a debug/loader port,
// routing synchronous read data back to its owner and counting CPU stall cycles.
module dmem_arbiter #(
   parameter int MAX_CPU_STREAK = 4,
   parameter int AW             = 8,
   parameter int DW             = 8
) (
   input  logic          clock,
   input  logic          reset_n,

   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_stall,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,

   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   output logic          dbg_gnt,
   output logic          dbg_rvalid,
   output logic [DW-1:0] dbg_rdata,

   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_wren,
   output logic          mem_rden,
   input  logic [DW-1:0] mem_q,

   input  logic          stat_clear,
   output logic [15:0]   stall_count
);

   localparam logic [3:0] STREAK_MAX = 4'(MAX_CPU_STREAK);

   logic [3:0]  streak_q,    streak_d;
   logic [1:0]  rd_owner_q,  rd_owner_d;   // {cpu, dbg}
   logic [15:0] stall_cnt_q, stall_cnt_d;

   logic dbg_turn;
   logic cpu_gnt_w;
   logic dbg_gnt_w;
   logic stall_w;

   // Grants are gated by reset_n so nothing reaches memory while reset is held.
   always_comb begin
      dbg_turn  = (streak_q >= STREAK_MAX);
      cpu_gnt_w = reset_n & cpu_req & ~(dbg_req & dbg_turn);
      dbg_gnt_w = reset_n & dbg_req & (~cpu_req | dbg_turn);
      stall_w   = reset_n & cpu_req & ~cpu_gnt_w;
   end

   always_comb begin
      mem_addr  = dbg_gnt_w ? dbg_addr  : cpu_addr;
      mem_wdata = dbg_gnt_w ? dbg_wdata : cpu_wdata;
      mem_wren  = (cpu_gnt_w & cpu_we)  | (dbg_gnt_w & dbg_we);
      mem_rden  = (cpu_gnt_w & ~cpu_we) | (dbg_gnt_w & ~dbg_we);
   end

   always_comb begin
      if (!dbg_req || dbg_gnt_w) begin
         streak_d = '0;
      end else if (cpu_gnt_w) begin
         streak_d = streak_q + 4'd1;
      end else begin
         streak_d = streak_q;
      end
   end

   always_comb begin
      rd_owner_d = {cpu_gnt_w & ~cpu_we, dbg_gnt_w & ~dbg_we};
   end

   always_comb begin
      if (stat_clear) begin
         stall_cnt_d = '0;
      end else if (stall_w && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         streak_q    <= '0;
         rd_owner_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         streak_q    <= streak_d;
         rd_owner_q  <= rd_owner_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   always_comb begin
      cpu_gnt     = cpu_gnt_w;
      dbg_gnt     = dbg_gnt_w;
      cpu_stall   = stall_w;
      cpu_rvalid  = rd_owner_q[1];
      dbg_rvalid  = rd_owner_q[0];
      cpu_rdata   = rd_owner_q[1] ? mem_q : '0;
      dbg_rdata   = rd_owner_q[0] ? mem_q : '0;
      stall_count = stall_cnt_q;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: random requesters checked every cycle against a behavioural model,
// plus directed cases with literal expectations; a second instance covers MAX_CPU_STREAK = 0.
module tb_dmem_arbiter;

   localparam int MAX = 4;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset_n;
   logic        cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
   logic [7:0]  cpu_addr, cpu_wdata, cpu_rdata;
   logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
   logic [7:0]  dbg_addr, dbg_wdata, dbg_rdata;
   logic [7:0]  mem_addr, mem_wdata, mem_q;
   logic        mem_wren, mem_rden;
   logic        stat_clear;
   logic [15:0] stall_count;

   logic        z_cpu_req, z_cpu_we, z_cpu_gnt, z_cpu_stall, z_cpu_rvalid;
   logic [7:0]  z_cpu_addr, z_cpu_wdata, z_cpu_rdata;
   logic        z_dbg_req, z_dbg_we, z_dbg_gnt, z_dbg_rvalid;
   logic [7:0]  z_dbg_addr, z_dbg_wdata, z_dbg_rdata;
   logic [7:0]  z_mem_addr, z_mem_wdata;
   logic [7:0]  z_mem_q;
   logic        z_mem_wren, z_mem_rden;
   logic        z_stat_clear;
   logic [15:0] z_stall_count;

   assign z_mem_q = 8'h3C;

   dmem_arbiter #(.MAX_CPU_STREAK(MAX), .AW(8), .DW(8)) dut (
      .clock(clock), .reset_n(reset_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_rden(mem_rden),
      .mem_q(mem_q), .stat_clear(stat_clear), .stall_count(stall_count)
   );

   dmem_arbiter #(.MAX_CPU_STREAK(0), .AW(8), .DW(8)) dut0 (
      .clock(clock), .reset_n(reset_n),
      .cpu_req(z_cpu_req), .cpu_we(z_cpu_we), .cpu_addr(z_cpu_addr), .cpu_wdata(z_cpu_wdata),
      .cpu_gnt(z_cpu_gnt), .cpu_stall(z_cpu_stall), .cpu_rvalid(z_cpu_rvalid), .cpu_rdata(z_cpu_rdata),
      .dbg_req(z_dbg_req), .dbg_we(z_dbg_we), .dbg_addr(z_dbg_addr), .dbg_wdata(z_dbg_wdata),
      .dbg_gnt(z_dbg_gnt), .dbg_rvalid(z_dbg_rvalid), .dbg_rdata(z_dbg_rdata),
      .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata), .mem_wren(z_mem_wren), .mem_rden(z_mem_rden),
      .mem_q(z_mem_q), .stat_clear(z_stat_clear), .stall_count(z_stall_count)
   );

   // Synchronous RAM driven by whatever the DUT puts on the memory port.
   bit [7:0] env_mem [256];
   always @(posedge clock) begin
      if (mem_rden) mem_q <= env_mem[mem_addr];
      if (mem_wren) env_mem[mem_addr] <= mem_wdata;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Behavioural model: contested-win run length, who owns next cycle's read data, stall total.
   bit [7:0] m_mem [256];
   int       m_run;
   bit       m_rd_cpu, m_rd_dbg;
   bit [7:0] m_rd_val;
   int       m_stall;
   bit       last_cg, last_dg;

   task automatic model_reset();
      m_run    = 0;
      m_rd_cpu = 0;
      m_rd_dbg = 0;
      m_rd_val = '0;
      m_stall  = 0;
   endtask

   task automatic step();
      bit       e_cg, e_dg, both, e_wr, e_rd, stall;
      bit [7:0] e_addr, e_wd;
      #1;
      both = cpu_req && dbg_req;
      if (!reset_n) begin
         e_cg = 0; e_dg = 0;
      end else if (both) begin
         e_cg = (m_run < MAX);
         e_dg = !e_cg;
      end else begin
         e_cg = cpu_req; e_dg = dbg_req;
      end
      e_addr = e_dg ? dbg_addr  : cpu_addr;
      e_wd   = e_dg ? dbg_wdata : cpu_wdata;
      e_wr   = (e_cg && cpu_we)  || (e_dg && dbg_we);
      e_rd   = (e_cg && !cpu_we) || (e_dg && !dbg_we);
      stall  = reset_n && cpu_req && !e_cg;
      check("cpu_gnt",     cpu_gnt,     e_cg);
      check("dbg_gnt",     dbg_gnt,     e_dg);
      check("cpu_stall",   cpu_stall,   stall);
      check("mem_addr",    mem_addr,    e_addr);
      check("mem_wdata",   mem_wdata,   e_wd);
      check("mem_wren",    mem_wren,    e_wr);
      check("mem_rden",    mem_rden,    e_rd);
      check("cpu_rvalid",  cpu_rvalid,  m_rd_cpu);
      check("cpu_rdata",   cpu_rdata,   m_rd_cpu ? m_rd_val : 8'h00);
      check("dbg_rvalid",  dbg_rvalid,  m_rd_dbg);
      check("dbg_rdata",   dbg_rdata,   m_rd_dbg ? m_rd_val : 8'h00);
      check("stall_count", stall_count, m_stall);
      last_cg = e_cg;
      last_dg = e_dg;
      @(posedge clock);
      if (!reset_n) begin
         model_reset();
      end else begin
         m_rd_cpu = e_cg && !cpu_we;
         m_rd_dbg = e_dg && !dbg_we;
         if (e_rd) m_rd_val = m_mem[e_addr];
         if (e_wr) m_mem[e_addr] = e_wd;
         m_run = (both && e_cg) ? m_run + 1 : 0;
         if (stat_clear) m_stall = 0;
         else if (stall && m_stall < 65535) m_stall++;
      end
      #1;
   endtask

   initial begin
      model_reset();
      last_cg = 0; last_dg = 0;
      reset_n = 0; stat_clear = 0;
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h77; cpu_wdata = 8'h99;
      dbg_req = 1; dbg_we = 1; dbg_addr = 8'h55; dbg_wdata = 8'h11;
      z_cpu_req = 0; z_cpu_we = 0; z_cpu_addr = 8'h00; z_cpu_wdata = 8'h00;
      z_dbg_req = 0; z_dbg_we = 0; z_dbg_addr = 8'h00; z_dbg_wdata = 8'h00;
      z_stat_clear = 0;

      // Reset: no grants even with requests, memory port follows the CPU inputs.
      repeat (2) @(posedge clock);
      #1;
      check("rst_cpu_gnt",  cpu_gnt,     1'b0);
      check("rst_dbg_gnt",  dbg_gnt,     1'b0);
      check("rst_mem_rden", mem_rden,    1'b0);
      check("rst_mem_wren", mem_wren,    1'b0);
      check("rst_mem_addr", mem_addr,    8'h77);
      check("rst_mem_wd",   mem_wdata,   8'h99);
      check("rst_stallcnt", stall_count, 16'h0000);
      step();
      cpu_req = 0; dbg_req = 0;
      reset_n = 1;
      step();

      // CPU writes 5A to 0x10, then reads it back.
      cpu_req = 1; cpu_we = 1; cpu_addr = 8'h10; cpu_wdata = 8'h5A;
      step();
      cpu_we = 0;
      #1;
      check("rd10_cpu_gnt",  cpu_gnt,  1'b1);
      check("rd10_mem_rden", mem_rden, 1'b1);
      check("rd10_mem_addr", mem_addr, 8'h10);
      step();
      cpu_req = 0;
      #1;
      check("rd10_rvalid",     cpu_rvalid, 1'b1);
      check("rd10_rdata",      cpu_rdata,  8'h5A);
      check("rd10_dbg_rvalid", dbg_rvalid, 1'b0);
      step();

      // Contention from a zero streak: CPU x4, DBG, CPU.
      cpu_req = 1; cpu_we = 1; cpu_addr = 8'h40; cpu_wdata = 8'hC4;
      dbg_req = 1; dbg_we = 0; dbg_addr = 8'h41;
      for (int c = 0; c < 6; c++) begin
         #1;
         check($sformatf("contend_cpu_gnt[%0d]", c), cpu_gnt, (c != 4));
         check($sformatf("contend_dbg_gnt[%0d]", c), dbg_gnt, (c == 4));
         if (c == 5) check("contend_stall_count", stall_count, 16'd1);
         step();
      end
      cpu_req = 0; dbg_req = 0;
      step();

      // DBG writes A3 to 0x20, CPU reads it.
      dbg_req = 1; dbg_we = 1; dbg_addr = 8'h20; dbg_wdata = 8'hA3;
      #1;
      check("dbgwr_gnt",      dbg_gnt,   1'b1);
      check("dbgwr_mem_wren", mem_wren,  1'b1);
      check("dbgwr_mem_addr", mem_addr,  8'h20);
      check("dbgwr_mem_wd",   mem_wdata, 8'hA3);
      step();
      dbg_req = 0;
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h20;
      #1;
      check("rd20_cpu_gnt", cpu_gnt, 1'b1);
      step();
      cpu_req = 0;
      #1;
      check("rd20_rvalid", cpu_rvalid, 1'b1);
      check("rd20_rdata",  cpu_rdata,  8'hA3);
      step();

      // Randomised requesters that hold their request until the model says granted.
      for (int c = 0; c < 1500; c++) begin
         if (!cpu_req || last_cg) begin
            cpu_req   = ($urandom_range(0, 3) != 0);
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = 8'($urandom_range(0, 15));
            cpu_wdata = 8'($urandom);
         end
         if (!dbg_req || last_dg) begin
            dbg_req   = 1'($urandom_range(0, 1));
            dbg_we    = 1'($urandom_range(0, 1));
            dbg_addr  = 8'($urandom_range(0, 15));
            dbg_wdata = 8'($urandom);
         end
         stat_clear = ($urandom_range(0, 63) == 0);
         step();
      end
      stat_clear = 0;
      cpu_req = 0; dbg_req = 0;
      step();

      // Stall, then reset in the middle of a read return.
      cpu_req = 1; dbg_req = 1; cpu_we = 1; dbg_we = 1; cpu_addr = 8'h30; dbg_addr = 8'h31;
      repeat (5) step();
      dbg_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
      step();
      cpu_req = 0;
      #1;
      check("mid_rvalid_before", cpu_rvalid, 1'b1);
      reset_n = 0;
      model_reset();
      #1;
      check("mid_rvalid_reset", cpu_rvalid,  1'b0);
      check("mid_rdata_reset",  cpu_rdata,   8'h00);
      check("mid_stall_reset",  stall_count, 16'h0000);
      cpu_req = 1; dbg_req = 1; cpu_we = 0; dbg_we = 0;
      repeat (2) step();
      reset_n = 1;
      #1;
      check("post_rst_cpu_gnt", cpu_gnt, 1'b1);
      check("post_rst_dbg_gnt", dbg_gnt, 1'b0);
      step();
      cpu_req = 0; dbg_req = 0;
      step();

      // MAX_CPU_STREAK = 0: DBG wins every tie; stall counter saturation and clear.
      z_cpu_req = 1; z_dbg_req = 1; z_cpu_we = 1; z_dbg_we = 1;
      z_cpu_addr = 8'h01; z_dbg_addr = 8'h02;
      #1;
      check("z_first_dbg_gnt", z_dbg_gnt,   1'b1);
      check("z_first_cpu_gnt", z_cpu_gnt,   1'b0);
      check("z_first_stall",   z_cpu_stall, 1'b1);
      @(posedge clock); #1;
      z_dbg_req = 0;
      #1;
      check("z_second_cpu_gnt", z_cpu_gnt,     1'b1);
      check("z_second_stall",   z_cpu_stall,   1'b0);
      check("z_count_one",      z_stall_count, 16'd1);
      @(posedge clock); #1;
      z_dbg_req = 1;
      repeat (65533) @(posedge clock);
      #1;
      check("z_count_fffe", z_stall_count, 16'hFFFE);
      @(posedge clock); #1;
      check("z_count_ffff", z_stall_count, 16'hFFFF);
      repeat (2) @(posedge clock);
      #1;
      check("z_count_sat", z_stall_count, 16'hFFFF);
      z_stat_clear = 1;
      #1;
      check("z_clear_stall", z_cpu_stall, 1'b1);
      @(posedge clock); #1;
      z_stat_clear = 0;
      check("z_count_clear", z_stall_count, 16'h0000);
      z_cpu_req = 0; z_dbg_req = 0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
